// File: rtl/pla_in0_pkg.sv
// Shared types and constants for the in0 PLA inverse-search engine.
package pla_in0_pkg;

  localparam int X_W   = 15;
  localparam int Z_W   = 11;
  localparam int SPACE = 32768;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Z_W-1:0] z_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DRAIN,
    ST_RESP
  } inv_state_e;

  // Only bits set in the care mask take part in the comparison.
  function automatic logic z_match(input z_t z, input z_t target, input z_t mask);
    return ((z ^ target) & mask) == '0;
  endfunction

endpackage

// File: rtl/pla_in0_inv_pipe.sv
// LAT-deep candidate/valid delay line that lines issued candidates up with
// the PLA response; flush_i kills every in-flight candidate.
module pla_in0_inv_pipe
  import pla_in0_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  input  x_t   x_i,
  output logic valid_o,
  output x_t   x_o
);

  if (LAT == 0) begin : g_comb
    // Combinational PLA: the response belongs to the candidate on pla_x now.
    logic unused_lat0;
    assign unused_lat0 = ^{clk_i, rst_ni, flush_i};
    assign valid_o     = valid_i;
    assign x_o         = x_i;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q;
    x_t             x_q [LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < LAT; i++) x_q[i] <= '0;
      end else begin
        vld_q[0] <= valid_i & ~flush_i;
        x_q[0]   <= x_i;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1] & ~flush_i;
          x_q[i]   <= x_q[i-1];
        end
      end
    end

    assign valid_o = vld_q[LAT-1];
    assign x_o     = x_q[LAT-1];
  end

endmodule

// File: rtl/pla_in0_inverse_search.sv
// Sequential inverse lookup over the 15-bit in0 PLA input space.
// Define PLA_IN0_INV_COUNT_EN to run the full sweep and count every match.
module pla_in0_inverse_search
  import pla_in0_pkg::*;
#(
  parameter int PLA_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  z_t   req_target,
  input  z_t   req_mask,
  input  x_t   req_start,
  output x_t   pla_x,
  output logic pla_x_valid,
  input  z_t   pla_z,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_found,
  output x_t   rsp_x
`ifdef PLA_IN0_INV_COUNT_EN
  ,
  output logic [15:0] rsp_count
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid holds its payload stable until that edge.

  localparam logic [1:0] DRAIN_LAST = (PLA_LAT == 0) ? 2'd0 : 2'(PLA_LAT - 1);
  localparam x_t         LAST_ISSUE = x_t'(SPACE - 1);

  inv_state_e state_q, state_d;
  x_t         cand_q, cand_d;
  x_t         issued_q, issued_d;
  logic [1:0] drain_q, drain_d;
  z_t         target_q, target_d;
  z_t         mask_q, mask_d;
  logic       found_q, found_d;
  x_t         rx_q, rx_d;
`ifdef PLA_IN0_INV_COUNT_EN
  logic [15:0] count_q, count_d;
`endif

  logic searching;
  logic flush;
  logic pipe_valid;
  x_t   pipe_x;
  logic hit;

  assign searching = (state_q == ST_SEARCH);

  pla_in0_inv_pipe #(.LAT(PLA_LAT)) u_pipe (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .valid_i (searching),
    .x_i     (cand_q),
    .valid_o (pipe_valid),
    .x_o     (pipe_x)
  );

  assign hit = pipe_valid && (state_q == ST_SEARCH || state_q == ST_DRAIN) &&
               z_match(pla_z, target_q, mask_q);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    issued_d = issued_q;
    drain_d  = drain_q;
    target_d = target_q;
    mask_d   = mask_q;
    found_d  = found_q;
    rx_d     = rx_q;
    flush    = 1'b0;
`ifdef PLA_IN0_INV_COUNT_EN
    count_d  = count_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          mask_d   = req_mask;
          cand_d   = req_start;
          issued_d = '0;
          drain_d  = '0;
          found_d  = 1'b0;
          rx_d     = '0;
`ifdef PLA_IN0_INV_COUNT_EN
          count_d  = '0;
`endif
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        cand_d   = cand_q + x_t'(1);
        issued_d = issued_q + x_t'(1);
        if (issued_q == LAST_ISSUE) state_d = (PLA_LAT == 0) ? ST_RESP : ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A match overrides the sweep bookkeeping above.
    if (hit) begin
      if (!found_q) begin
        found_d = 1'b1;
        rx_d    = pipe_x;
      end
`ifdef PLA_IN0_INV_COUNT_EN
      count_d = count_q + 16'd1;
`else
      state_d = ST_RESP;
      flush   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      issued_q <= '0;
      drain_q  <= '0;
      target_q <= '0;
      mask_q   <= '0;
      found_q  <= 1'b0;
      rx_q     <= '0;
`ifdef PLA_IN0_INV_COUNT_EN
      count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      found_q  <= found_d;
      rx_q     <= rx_d;
`ifdef PLA_IN0_INV_COUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign pla_x_valid = searching;
  assign pla_x       = searching ? cand_q : '0;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_found   = found_q;
  assign rsp_x       = rx_q;
`ifdef PLA_IN0_INV_COUNT_EN
  assign rsp_count   = count_q;
`endif

endmodule
